// File: rtl/des_pipe_pkg.sv
// Shared constants and helpers for the DES datapath pipeline registers.
// Width/depth choices for DES users and a constant-safe clog2.
package des_pipe_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_HALF_W  = 32;
  localparam int DES_ROUNDS  = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/des_skid_stage.sv
// One 2-entry skid stage: registered in_ready, full throughput.
// The skid slot only fills when main is held, so skid_v implies main_v.
module des_skid_stage
  import des_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             deliver;

  assign in_ready  = ~skid_v_q & en & ~flush;
  assign accept    = in_valid & in_ready;
  assign deliver   = main_v_q & out_ready & en;
  assign out_valid = main_v_q;
  assign out_data  = main_q;
  assign occ       = {1'b0, main_v_q} + {1'b0, skid_v_q};

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (en) begin
      if (!main_v_q || deliver) begin
        skid_v_d = 1'b0;
        if (skid_v_q) begin
          main_v_d = 1'b1;
          main_d   = skid_q;
        end else if (accept) begin
          main_v_d = 1'b1;
          main_d   = in_data;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (accept) begin
        skid_v_d = 1'b1;
        skid_d   = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/des_pipe_reg.sv
// Parametrised DES pipeline register: DEPTH cascaded skid stages
// with global stall, synchronous flush and an occupancy count.
module des_pipe_reg
  import des_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic                             en,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [clog2(2*DEPTH+1)-1:0]      count
);

  localparam int CW = clog2(2*DEPTH+1);

  logic [DEPTH:0]              v;
  logic [DEPTH:0]              r;
  logic [DEPTH:0][WIDTH-1:0]   d;
  logic [DEPTH-1:0][1:0]       occ;
  logic [CW-1:0]               cnt;

  assign v[0]      = in_valid;
  assign d[0]      = in_data;
  assign in_ready  = r[0];
  assign out_valid = v[DEPTH];
  assign out_data  = d[DEPTH];
  assign r[DEPTH]  = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    des_skid_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .res      (res),
      .en       (en),
      .flush    (flush),
      .in_valid (v[k]),
      .in_ready (r[k]),
      .in_data  (d[k]),
      .out_valid(v[k+1]),
      .out_ready(r[k+1]),
      .out_data (d[k+1]),
      .occ      (occ[k])
    );
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + CW'(occ[k]);
    end
  end

  assign count = cnt;

endmodule
